// File: rtl/noc_flit_pkg.sv
// Flit field layout shared by the NoC injection buffers and the ejection-side sink.
package noc_flit_pkg;
   localparam int FLIT_W       = 20;
   localparam int NODE_W       = 4;
   localparam int NUM_NODES    = 16;
   localparam int RSVD_W       = 4;
   localparam int SRC_LSB      = 12;
   localparam int DEST_LSB     = 4;
   localparam int DEST_CHK_LSB = 0;
   localparam int RSVD_HI_LSB  = 16;
   localparam int RSVD_LO_LSB  = 8;
endpackage

// File: rtl/datain_fifo.sv
// Synchronous FIFO with registered read port; a push into a full FIFO is taken
// only when a pop retires an entry on the same edge.
module datain_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         accept,
   output logic [W-1:0] rd_data,
   output logic         rd_valid,
   output logic         empty,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [W-1:0]  rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          do_pop;

   assign empty  = (count_q == '0);
   assign full   = (count_q == (AW+1)'(DEPTH));
   assign do_pop = pop & ~empty;
   assign accept = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = do_pop;
      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop) begin
         rd_ptr_d  = rd_ptr_q + AW'(1);
         rd_data_d = mem_q[rd_ptr_q];
      end
      case ({accept, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Storage is not reset; pointers and occupancy make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= push_data;
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
endmodule

// File: rtl/datain_sink_buf.sv
// NoC ejection-port sink: checks, counts and buffers flits addressed to NODE_ID.
// Define DATAIN_SINK_CHECK_EN to enable destination/reserved-field checking.
module datain_sink_buf
   import noc_flit_pkg::*;
#(
   parameter int                   NODE_ID     = 0,
   parameter int                   DEPTH       = 16,
   parameter logic [NUM_NODES-1:0] EXPECT_MASK = 16'hFFFE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [FLIT_W-1:0]    datain,
   input  logic                 rd_en,
   output logic [FLIT_W-1:0]    rd_data,
   output logic                 rd_valid,
   output logic                 empty,
   output logic                 full,
   output logic [4:0]           rx_count,
   output logic [NUM_NODES-1:0] src_seen,
   output logic                 all_rx,
   output logic                 misroute_err,
   output logic                 overflow
);
   logic [NODE_W-1:0]    src;
   logic                 flit_ok;
   logic                 push;
   logic                 accept;
   logic [4:0]           rx_count_q, rx_count_d;
   logic [NUM_NODES-1:0] src_seen_q, src_seen_d;
   logic                 overflow_q, overflow_d;

   assign src = datain[SRC_LSB +: NODE_W];

`ifdef DATAIN_SINK_CHECK_EN
   logic misroute_q, misroute_d;

   assign flit_ok = (datain[DEST_LSB +: NODE_W] == NODE_W'(NODE_ID)) &&
                    (datain[DEST_CHK_LSB +: NODE_W] == datain[DEST_LSB +: NODE_W]) &&
                    (datain[RSVD_HI_LSB +: RSVD_W] == '0) &&
                    (datain[RSVD_LO_LSB +: RSVD_W] == '0);

   always_comb begin
      misroute_d = misroute_q | (in_valid & ~flit_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) misroute_q <= 1'b0;
      else     misroute_q <= misroute_d;
   end

   assign misroute_err = misroute_q;
`else
   logic unused_fields;

   assign flit_ok       = 1'b1;
   assign misroute_err  = 1'b0;
   assign unused_fields = ^{datain[RSVD_HI_LSB +: RSVD_W], datain[RSVD_LO_LSB +: RSVD_W],
                            datain[DEST_LSB +: NODE_W], datain[DEST_CHK_LSB +: NODE_W],
                            NODE_W'(NODE_ID)};
`endif

   assign push = in_valid & flit_ok;

   datain_fifo #(.DEPTH(DEPTH), .W(FLIT_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (datain),
      .pop       (rd_en),
      .accept    (accept),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .empty     (empty),
      .full      (full)
   );

   // Counters and bitmap follow the FIFO's accept, so dropped flits leave no trace.
   always_comb begin
      rx_count_d = rx_count_q;
      src_seen_d = src_seen_q;
      overflow_d = overflow_q | (push & ~accept);
      if (accept) begin
         if (rx_count_q != 5'd31) rx_count_d = rx_count_q + 5'd1;
         src_seen_d = src_seen_q | (NUM_NODES'(1) << src);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_count_q <= '0;
         src_seen_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         rx_count_q <= rx_count_d;
         src_seen_q <= src_seen_d;
         overflow_q <= overflow_d;
      end
   end

   assign rx_count = rx_count_q;
   assign src_seen = src_seen_q;
   assign overflow = overflow_q;
   assign all_rx   = ((src_seen_q & EXPECT_MASK) == EXPECT_MASK);
endmodule
